// File: rtl/fofb_tx_arbiter_if.sv
// TLP source stream towards the Tx arbiter: request, active-high framing, and
// the grant/ready/abort returned by the arbiter.
interface fofb_tx_arbiter_if;
    logic        req;
    logic [63:0] td;
    logic [7:0]  trem_n;
    logic        sof;
    logic        eof;
    logic        valid;
    logic        gnt;
    logic        ready;
    logic        abort;

    modport master (
        output req, td, trem_n, sof, eof, valid,
        input  gnt, ready, abort
    );

    modport slave (
        input  req, td, trem_n, sof, eof, valid,
        output gnt, ready, abort
    );
endinterface

// File: rtl/fofb_tx_arbiter.sv
// Packet-granular arbiter sharing the TRN Tx port between the completion engine
// and the FOFB DMA write engine, with credit checks and a DMA starvation guard.
module fofb_tx_arbiter #(
    parameter int unsigned CPL_BURST = 4
) (
    input  logic                trn_clk,
    input  logic                trn_reset,
    input  logic                trn_lnk_up_n,
    input  logic [3:0]          trn_tbuf_av,
    input  logic                trn_tdst_rdy_n,
    input  logic                trn_tdst_dsc_n,
    output logic [63:0]         trn_td,
    output logic [7:0]          trn_trem_n,
    output logic                trn_tsof_n,
    output logic                trn_teof_n,
    output logic                trn_tsrc_rdy_n,
    output logic                trn_tsrc_dsc_n,
    fofb_tx_arbiter_if.slave    cpl_if,
    fofb_tx_arbiter_if.slave    dma_if,
    output logic [15:0]         cpl_pkt_cnt_o,
    output logic [15:0]         dma_pkt_cnt_o,
    output logic [7:0]          dsc_cnt_o
);

    localparam int unsigned BurstW = ($clog2(CPL_BURST + 1) > 3) ? $clog2(CPL_BURST + 1) : 3;
    localparam logic [BurstW-1:0] BurstMax = BurstW'(CPL_BURST);

    typedef enum logic [1:0] {StIdle, StCpl, StDma} state_e;

    state_e              state_q, state_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [15:0]         cpl_cnt_q, cpl_cnt_d;
    logic [15:0]         dma_cnt_q, dma_cnt_d;
    logic [7:0]          dsc_cnt_q, dsc_cnt_d;
    logic                cpl_abort_q, cpl_abort_d;
    logic                dma_abort_q, dma_abort_d;

    logic cpl_ok, dma_ok;
    logic in_cpl, in_dma, granted;
    logic src_valid, src_eof;
    logic xfer, abort, dsc, eof_done;

    // Only posted (bit 1) and completion (bit 2) credits matter here.
    logic unused_tbuf;
    assign unused_tbuf = ^{trn_tbuf_av[3], trn_tbuf_av[0]};

    always_comb begin
        cpl_ok    = cpl_if.req & trn_tbuf_av[2];
        dma_ok    = dma_if.req & trn_tbuf_av[1];
        in_cpl    = (state_q == StCpl);
        in_dma    = (state_q == StDma);
        granted   = in_cpl | in_dma;
        src_valid = in_cpl ? cpl_if.valid : dma_if.valid;
        src_eof   = in_cpl ? cpl_if.eof : dma_if.eof;
        xfer      = granted & src_valid & ~trn_tdst_rdy_n;
        // Link-down aborts like a discontinue but is not counted as one.
        abort     = granted & (trn_lnk_up_n | ~trn_tdst_dsc_n);
        dsc       = granted & ~trn_tdst_dsc_n & ~trn_lnk_up_n;
        eof_done  = xfer & src_eof & ~abort;
    end

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        cpl_cnt_d   = cpl_cnt_q;
        dma_cnt_d   = dma_cnt_q;
        dsc_cnt_d   = dsc_cnt_q;
        cpl_abort_d = in_cpl & abort;
        dma_abort_d = in_dma & abort;

        case (state_q)
            StIdle: begin
                if (!trn_lnk_up_n) begin
                    if (dma_ok && (burst_q == BurstMax)) begin
                        state_d = StDma;
                        burst_d = '0;
                    end else if (cpl_ok) begin
                        state_d = StCpl;
                        if (dma_if.req) begin
                            burst_d = (burst_q == BurstMax) ? burst_q : burst_q + 1'b1;
                        end else begin
                            burst_d = '0;
                        end
                    end else if (dma_ok) begin
                        state_d = StDma;
                        burst_d = '0;
                    end
                end
            end
            StCpl, StDma: begin
                if (abort || eof_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_cpl && eof_done) begin
            cpl_cnt_d = cpl_cnt_q + 16'd1;
        end
        if (in_dma && eof_done) begin
            dma_cnt_d = dma_cnt_q + 16'd1;
        end
        if (dsc && (dsc_cnt_q != 8'hFF)) begin
            dsc_cnt_d = dsc_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge trn_clk or posedge trn_reset) begin
        if (trn_reset) begin
            state_q     <= StIdle;
            burst_q     <= '0;
            cpl_cnt_q   <= '0;
            dma_cnt_q   <= '0;
            dsc_cnt_q   <= '0;
            cpl_abort_q <= 1'b0;
            dma_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            cpl_cnt_q   <= cpl_cnt_d;
            dma_cnt_q   <= dma_cnt_d;
            dsc_cnt_q   <= dsc_cnt_d;
            cpl_abort_q <= cpl_abort_d;
            dma_abort_q <= dma_abort_d;
        end
    end

    always_comb begin
        trn_td         = '0;
        trn_trem_n     = 8'h00;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        trn_tsrc_dsc_n = 1'b1;
        if (in_cpl) begin
            trn_td         = cpl_if.td;
            trn_trem_n     = cpl_if.trem_n;
            trn_tsof_n     = ~cpl_if.sof;
            trn_teof_n     = ~cpl_if.eof;
            trn_tsrc_rdy_n = ~cpl_if.valid;
        end else if (in_dma) begin
            trn_td         = dma_if.td;
            trn_trem_n     = dma_if.trem_n;
            trn_tsof_n     = ~dma_if.sof;
            trn_teof_n     = ~dma_if.eof;
            trn_tsrc_rdy_n = ~dma_if.valid;
        end
    end

    assign cpl_if.gnt    = in_cpl;
    assign cpl_if.ready  = in_cpl & ~trn_tdst_rdy_n;
    assign cpl_if.abort  = cpl_abort_q;
    assign dma_if.gnt    = in_dma;
    assign dma_if.ready  = in_dma & ~trn_tdst_rdy_n;
    assign dma_if.abort  = dma_abort_q;

    assign cpl_pkt_cnt_o = cpl_cnt_q;
    assign dma_pkt_cnt_o = dma_cnt_q;
    assign dsc_cnt_o     = dsc_cnt_q;

endmodule

// File: tb/tb_fofb_tx_arbiter.sv
// Directed bench for fofb_tx_arbiter; inputs change and outputs are sampled
// just after the falling edge.
module tb_fofb_tx_arbiter;

    logic        trn_clk = 1'b0;
    logic        trn_reset;
    logic        trn_lnk_up_n;
    logic [3:0]  trn_tbuf_av;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic [15:0] cpl_pkt_cnt, dma_pkt_cnt;
    logic [7:0]  dsc_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    fofb_tx_arbiter_if cpl_bus ();
    fofb_tx_arbiter_if dma_bus ();

    fofb_tx_arbiter #(.CPL_BURST(4)) dut (
        .trn_clk        (trn_clk),
        .trn_reset      (trn_reset),
        .trn_lnk_up_n   (trn_lnk_up_n),
        .trn_tbuf_av    (trn_tbuf_av),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .trn_tdst_dsc_n (trn_tdst_dsc_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
        .cpl_if         (cpl_bus),
        .dma_if         (dma_bus),
        .cpl_pkt_cnt_o  (cpl_pkt_cnt),
        .dma_pkt_cnt_o  (dma_pkt_cnt),
        .dsc_cnt_o      (dsc_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_srcs();
        cpl_bus.req = 1'b0; cpl_bus.td = '0; cpl_bus.trem_n = 8'h00;
        cpl_bus.sof = 1'b0; cpl_bus.eof = 1'b0; cpl_bus.valid = 1'b0;
        dma_bus.req = 1'b0; dma_bus.td = '0; dma_bus.trem_n = 8'h00;
        dma_bus.sof = 1'b0; dma_bus.eof = 1'b0; dma_bus.valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cpl_gnt"}, cpl_bus.gnt, 1'b0);
        check_eq({tag, "_dma_gnt"}, dma_bus.gnt, 1'b0);
        check_eq({tag, "_td"}, trn_td, 64'h0);
        check_eq({tag, "_ctrl"}, {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 4'hF);
    endtask

    initial begin
        logic [63:0] base;
        int got;
        int beats;
        int nogrant;

        trn_reset      = 1'b1;
        trn_lnk_up_n   = 1'b0;
        trn_tbuf_av    = 4'b0110;
        trn_tdst_rdy_n = 1'b0;
        trn_tdst_dsc_n = 1'b1;
        idle_srcs();

        // Reset values
        @(negedge trn_clk); @(negedge trn_clk); #1;
        check_idle_outputs("rst");
        check_eq("rst_trem", trn_trem_n, 8'h00);
        check_eq("rst_cnts", {cpl_pkt_cnt, dma_pkt_cnt, dsc_cnt}, 40'h0);
        check_eq("rst_abort", {cpl_bus.abort, dma_bus.abort}, 2'b00);
        @(negedge trn_clk); trn_reset = 1'b0;

        // Single 2-beat completion
        @(negedge trn_clk);
        cpl_bus.req = 1'b1; cpl_bus.td = 64'hC0DE_0001; cpl_bus.trem_n = 8'h0F;
        cpl_bus.sof = 1'b1; cpl_bus.valid = 1'b1;
        #1 check_eq("cpl_gnt_early", cpl_bus.gnt, 1'b0);
        check_eq("idle_rdy_n", trn_tsrc_rdy_n, 1'b1);
        @(negedge trn_clk); cpl_bus.req = 1'b0;
        #1 check_eq("cpl_gnt", cpl_bus.gnt, 1'b1);
        check_eq("cpl_sof", trn_tsof_n, 1'b0);
        check_eq("cpl_td1", trn_td, 64'hC0DE_0001);
        check_eq("cpl_trem", trn_trem_n, 8'h0F);
        check_eq("cpl_ready", cpl_bus.ready, 1'b1);
        check_eq("dma_gnt_ready_off", {dma_bus.gnt, dma_bus.ready}, 2'b00);
        @(negedge trn_clk);
        cpl_bus.sof = 1'b0; cpl_bus.eof = 1'b1; cpl_bus.td = 64'hC0DE_0002;
        #1 check_eq("cpl_eof", {trn_tsof_n, trn_teof_n}, 2'b10);
        check_eq("cpl_td2", trn_td, 64'hC0DE_0002);
        @(negedge trn_clk); idle_srcs();
        #1 check_idle_outputs("cpl_done");
        check_eq("cpl_cnt1", cpl_pkt_cnt, 16'd1);

        // Starvation guard: both requesting, 1-beat packets
        @(negedge trn_clk);
        cpl_bus.req = 1'b1; cpl_bus.valid = 1'b1; cpl_bus.sof = 1'b1; cpl_bus.eof = 1'b1;
        dma_bus.req = 1'b1; dma_bus.valid = 1'b1; dma_bus.sof = 1'b1; dma_bus.eof = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge trn_clk); #1;
            if (cpl_bus.gnt || dma_bus.gnt) begin
                check_eq($sformatf("order%0d", got), dma_bus.gnt, (got % 5 == 4));
                got++;
                if (got == 10) begin
                    cpl_bus.req = 1'b0;
                    dma_bus.req = 1'b0;
                end
            end
        end
        check_eq("order_count", got, 10);
        @(negedge trn_clk); idle_srcs();
        #1 check_eq("starve_cpl_cnt", cpl_pkt_cnt, 16'd9);
        check_eq("starve_dma_cnt", dma_pkt_cnt, 16'd2);

        // Credits: only posted credit available
        @(negedge trn_clk);
        trn_tbuf_av = 4'b0010;
        cpl_bus.req = 1'b1; cpl_bus.valid = 1'b1; cpl_bus.sof = 1'b1; cpl_bus.eof = 1'b1;
        dma_bus.req = 1'b1; dma_bus.valid = 1'b1; dma_bus.sof = 1'b1; dma_bus.eof = 1'b1;
        @(negedge trn_clk); dma_bus.req = 1'b0;
        #1 check_eq("credit_gnt", {cpl_bus.gnt, dma_bus.gnt}, 2'b01);
        @(negedge trn_clk);
        trn_tbuf_av = 4'b0000; dma_bus.req = 1'b1;
        #1 check_eq("credit_cpl_held", cpl_bus.gnt, 1'b0);
        check_eq("credit_dma_cnt", dma_pkt_cnt, 16'd3);
        nogrant = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge trn_clk); #1;
            if (cpl_bus.gnt || dma_bus.gnt) nogrant++;
        end
        check_eq("no_credit_grant", nogrant, 0);
        @(negedge trn_clk); idle_srcs(); trn_tbuf_av = 4'b0110;

        // Backpressure: 6-beat DMA packet, rdy_n toggling
        base = 64'hDA7A_0000_0000_0000;
        @(negedge trn_clk);
        dma_bus.req = 1'b1; dma_bus.valid = 1'b1; dma_bus.sof = 1'b1; dma_bus.td = base;
        beats = 0;
        for (int c = 0; c < 30 && beats < 6; c++) begin
            @(negedge trn_clk);
            dma_bus.req    = 1'b0;
            trn_tdst_rdy_n = (c % 2 == 1);
            dma_bus.td     = base + 64'(beats);
            dma_bus.sof    = (beats == 0);
            dma_bus.eof    = (beats == 5);
            dma_bus.valid  = 1'b1;
            #1 check_eq("bp_ready", dma_bus.ready, !trn_tdst_rdy_n);
            if (!trn_tdst_rdy_n) begin
                check_eq($sformatf("bp_beat%0d", beats), trn_td, base + 64'(beats));
                beats++;
            end
        end
        check_eq("bp_beats", beats, 6);
        @(negedge trn_clk); idle_srcs(); trn_tdst_rdy_n = 1'b0;
        #1 check_eq("bp_gnt_off", dma_bus.gnt, 1'b0);
        check_eq("bp_dma_cnt", dma_pkt_cnt, 16'd4);

        // Discontinue on beat 3 of a DMA packet
        @(negedge trn_clk);
        dma_bus.req = 1'b1; dma_bus.valid = 1'b1; dma_bus.sof = 1'b1; dma_bus.td = 64'h100;
        @(negedge trn_clk); dma_bus.req = 1'b0;
        @(negedge trn_clk); dma_bus.sof = 1'b0; dma_bus.td = 64'h101;
        @(negedge trn_clk); dma_bus.td = 64'h102; trn_tdst_dsc_n = 1'b0;
        #1 check_eq("dsc_abort_early", dma_bus.abort, 1'b0);
        @(negedge trn_clk); trn_tdst_dsc_n = 1'b1; idle_srcs();
        #1 check_eq("dsc_abort", dma_bus.abort, 1'b1);
        check_eq("dsc_gnt_off", dma_bus.gnt, 1'b0);
        check_eq("dsc_cnt1", dsc_cnt, 8'd1);
        check_eq("dsc_dma_cnt", dma_pkt_cnt, 16'd4);
        check_eq("dsc_cpl_abort", cpl_bus.abort, 1'b0);
        @(negedge trn_clk);
        cpl_bus.req = 1'b1; cpl_bus.valid = 1'b1; cpl_bus.sof = 1'b1; cpl_bus.eof = 1'b1;
        #1 check_eq("dsc_abort_once", dma_bus.abort, 1'b0);
        @(negedge trn_clk); cpl_bus.req = 1'b0;
        #1 check_eq("dsc_next_cpl_gnt", cpl_bus.gnt, 1'b1);
        @(negedge trn_clk); idle_srcs();
        #1 check_eq("dsc_cpl_cnt", cpl_pkt_cnt, 16'd10);

        // Link down mid-packet
        @(negedge trn_clk);
        dma_bus.req = 1'b1; dma_bus.valid = 1'b1; dma_bus.sof = 1'b1; dma_bus.td = 64'h200;
        @(negedge trn_clk); dma_bus.req = 1'b0;
        #1 check_eq("lnk_gnt", dma_bus.gnt, 1'b1);
        @(negedge trn_clk); dma_bus.sof = 1'b0; dma_bus.eof = 1'b1; trn_lnk_up_n = 1'b1;
        @(negedge trn_clk);
        dma_bus.req = 1'b1; dma_bus.sof = 1'b1; dma_bus.eof = 1'b0;
        #1 check_eq("lnk_abort", dma_bus.abort, 1'b1);
        check_eq("lnk_gnt_off", dma_bus.gnt, 1'b0);
        check_eq("lnk_dsc_cnt", dsc_cnt, 8'd1);
        check_eq("lnk_dma_cnt", dma_pkt_cnt, 16'd4);
        nogrant = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge trn_clk); #1;
            if (cpl_bus.gnt || dma_bus.gnt) nogrant++;
        end
        check_eq("lnk_no_grant", nogrant, 0);
        trn_lnk_up_n = 1'b0;
        @(negedge trn_clk); dma_bus.req = 1'b0; dma_bus.eof = 1'b1;
        #1 check_eq("lnk_regrant", dma_bus.gnt, 1'b1);
        @(negedge trn_clk); idle_srcs();
        #1 check_eq("lnk_dma_cnt2", dma_pkt_cnt, 16'd5);

        // Discontinue counter saturation
        for (int i = 0; i < 260; i++) begin
            @(negedge trn_clk);
            cpl_bus.req = 1'b1; cpl_bus.valid = 1'b1; cpl_bus.sof = 1'b1; cpl_bus.eof = 1'b0;
            @(negedge trn_clk); cpl_bus.req = 1'b0; trn_tdst_dsc_n = 1'b0;
            @(negedge trn_clk); trn_tdst_dsc_n = 1'b1; idle_srcs();
        end
        @(negedge trn_clk); #1;
        check_eq("dsc_sat", dsc_cnt, 8'd255);
        check_eq("dsc_sat_cpl_cnt", cpl_pkt_cnt, 16'd10);

        // Asynchronous reset mid-packet
        @(negedge trn_clk);
        cpl_bus.req = 1'b1; cpl_bus.valid = 1'b1; cpl_bus.sof = 1'b1; cpl_bus.td = 64'h300;
        @(negedge trn_clk); cpl_bus.req = 1'b0;
        #1 check_eq("rst_mid_gnt", cpl_bus.gnt, 1'b1);
        #1 trn_reset = 1'b1;
        #1 check_idle_outputs("rst_mid");
        check_eq("rst_mid_ready", {cpl_bus.ready, dma_bus.ready}, 2'b00);
        check_eq("rst_mid_cnts", {cpl_pkt_cnt, dma_pkt_cnt, dsc_cnt}, 40'h0);
        @(negedge trn_clk); trn_reset = 1'b0; idle_srcs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
